mem_stage_sram_ctrl: RTL and testbench

- MEM-stage data-memory controller. Sits directly downstream of the EXE/MEM pipeline register.
- Consumes the registered ALU result (byte address), Rm value (store data), MEM_R_EN and MEM_W_EN.
- Performs 32-bit loads and stores against an external 16-bit asynchronous SRAM in two half-word phases, each with fixed wait states.
- Drives `ready`; the hazard/freeze logic stalls all pipeline registers while `ready`=0.

---
 rtl/mem_stage_sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller: 32-bit loads/stores over a 16-bit async SRAM
// Each word moves as two half-word phases (LOW then HIGH) of WAIT_CYCLES each; o_ready freezes the pipe.
module mem_stage_sram_ctrl #(
   parameter int WORD_WIDTH      = 32,
   parameter int SRAM_DATA_WIDTH = 16,
   parameter int SRAM_ADDR_WIDTH = 18,
   parameter int WAIT_CYCLES     = 2,
   parameter int ADDR_BASE       = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_rd_en,
   input  logic                       i_wr_en,
   input  logic [WORD_WIDTH-1:0]      i_address,
   input  logic [WORD_WIDTH-1:0]      i_write_data,
   output logic [WORD_WIDTH-1:0]      o_read_data,
   output logic                       o_ready,
   output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] o_sram_dq_out,
   input  logic [SRAM_DATA_WIDTH-1:0] i_sram_dq_in,
   output logic                       o_sram_dq_oe,
   output logic                       o_sram_we_n
);

   localparam int HW   = SRAM_DATA_WIDTH;
   localparam int IDXW = SRAM_ADDR_WIDTH - 1;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [3:0]                 r_cnt, w_cnt_nxt;
   logic                       r_op_wr, w_op_wr_nxt;
   logic [IDXW-1:0]            r_word_idx, w_word_idx_nxt;
   logic [WORD_WIDTH-1:0]      r_wdata, w_wdata_nxt;
   logic [WORD_WIDTH-1:0]      r_read_data, w_read_data_nxt;
   logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr, w_sram_addr_nxt;
   logic [HW-1:0]              r_dq_out, w_dq_out_nxt;
   logic                       r_dq_oe, w_dq_oe_nxt;
   logic                       r_we_n, w_we_n_nxt;

   logic [WORD_WIDTH-1:0]      w_offset;
   logic                       w_req;
   logic                       w_unused;

   // Offset wraps modulo 2^WORD_WIDTH, so addresses below ADDR_BASE alias high in the SRAM.
   assign w_offset = i_address - WORD_WIDTH'(ADDR_BASE);
   assign w_req    = i_rd_en | i_wr_en;
   assign w_unused = ^{w_offset[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], w_offset[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_op_wr     <= 1'b0;
         r_word_idx  <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_we_n      <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_op_wr     <= w_op_wr_nxt;
         r_word_idx  <= w_word_idx_nxt;
         r_wdata     <= w_wdata_nxt;
         r_read_data <= w_read_data_nxt;
         r_sram_addr <= w_sram_addr_nxt;
         r_dq_out    <= w_dq_out_nxt;
         r_dq_oe     <= w_dq_oe_nxt;
         r_we_n      <= w_we_n_nxt;
      end
   end

   // Strobe values are computed for the state being entered, so they register in with it.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_op_wr_nxt     = r_op_wr;
      w_word_idx_nxt  = r_word_idx;
      w_wdata_nxt     = r_wdata;
      w_read_data_nxt = r_read_data;
      w_sram_addr_nxt = r_sram_addr;
      w_dq_out_nxt    = r_dq_out;
      w_dq_oe_nxt     = 1'b0;
      w_we_n_nxt      = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_op_wr_nxt     = i_wr_en;
               w_word_idx_nxt  = w_offset[SRAM_ADDR_WIDTH:2];
               w_wdata_nxt     = i_write_data;
               w_cnt_nxt       = CNT_LOAD;
               w_state_nxt     = S_LOW;
               w_sram_addr_nxt = {w_offset[SRAM_ADDR_WIDTH:2], 1'b0};
               if (i_wr_en) w_dq_out_nxt = i_write_data[HW-1:0];
               w_dq_oe_nxt     = i_wr_en;
               w_we_n_nxt      = ~i_wr_en;
            end
         end
         S_LOW: begin
            w_dq_oe_nxt = r_op_wr;
            w_we_n_nxt  = ~r_op_wr;
            if (r_cnt == 4'd0) begin
               if (!r_op_wr) w_read_data_nxt[HW-1:0] = i_sram_dq_in;
               w_cnt_nxt       = CNT_LOAD;
               w_state_nxt     = S_HIGH;
               w_sram_addr_nxt = {r_word_idx, 1'b1};
               if (r_op_wr) w_dq_out_nxt = r_wdata[WORD_WIDTH-1:HW];
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_HIGH: begin
            if (r_cnt == 4'd0) begin
               if (!r_op_wr) w_read_data_nxt[WORD_WIDTH-1:HW] = i_sram_dq_in;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
               w_dq_oe_nxt = r_op_wr;
               w_we_n_nxt  = ~r_op_wr;
            end
         end
         S_DONE: begin
            // Requests seen here belong to the instruction completing now.
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
   assign o_read_data   = r_read_data;
   assign o_sram_addr   = r_sram_addr;
   assign o_sram_dq_out = r_dq_out;
   assign o_sram_dq_oe  = r_dq_oe;
   assign o_sram_we_n   = r_we_n;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - directed bench for mem_stage_sram_ctrl with a 16-bit SRAM model
module tb_mem_stage_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_rd_en = 1'b0;
   logic        i_wr_en = 1'b0;
   logic [31:0] i_address = '0;
   logic [31:0] i_write_data = '0;
   logic [31:0] o_read_data;
   logic        o_ready;
   logic [17:0] o_sram_addr;
   logic [15:0] o_sram_dq_out;
   logic [15:0] i_sram_dq_in;
   logic        o_sram_dq_oe;
   logic        o_sram_we_n;

   logic [15:0] mem [0:262143];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage_sram_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_rd_en      (i_rd_en),
      .i_wr_en      (i_wr_en),
      .i_address    (i_address),
      .i_write_data (i_write_data),
      .o_read_data  (o_read_data),
      .o_ready      (o_ready),
      .o_sram_addr  (o_sram_addr),
      .o_sram_dq_out(o_sram_dq_out),
      .i_sram_dq_in (i_sram_dq_in),
      .o_sram_dq_oe (o_sram_dq_oe),
      .o_sram_we_n  (o_sram_we_n)
   );

   assign i_sram_dq_in = mem[o_sram_addr];

   always @(posedge clk) begin
      if (!o_sram_we_n && o_sram_dq_oe) mem[o_sram_addr] <= o_sram_dq_out;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] lo;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [17:0] lo, input logic [31:0] exp_rd);
      logic [17:0] at [16];
      logic        wt [16];
      logic        ot [16];
      logic [15:0] dt [16];
      int          lat;
      logic [31:0] rdv;
      for (int k = 0; k < 16; k++) begin
         at[k] = '0; wt[k] = 1'b1; ot[k] = 1'b0; dt[k] = '0;
      end
      lat = -1;
      rdv = '0;
      i_rd_en = rd; i_wr_en = wr; i_address = addr; i_write_data = wdata;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         at[k] = o_sram_addr; wt[k] = o_sram_we_n; ot[k] = o_sram_dq_oe; dt[k] = o_sram_dq_out;
         if (o_ready) begin
            lat = k;
            rdv = o_read_data;
            break;
         end
      end
      @(posedge clk); #1;
      i_rd_en = 1'b0; i_wr_en = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'd5);
      chk({tag, " lo addr c1"}, 32'(at[1]), 32'(lo));
      chk({tag, " lo addr c2"}, 32'(at[2]), 32'(lo));
      chk({tag, " hi addr c3"}, 32'(at[3]), 32'(lo | 18'd1));
      chk({tag, " hi addr c4"}, 32'(at[4]), 32'(lo | 18'd1));
      chk({tag, " we_n c0..5"}, 32'({wt[0], wt[1], wt[2], wt[3], wt[4], wt[5]}),
          wr ? 32'b100001 : 32'b111111);
      chk({tag, " oe c0..5"}, 32'({ot[0], ot[1], ot[2], ot[3], ot[4], ot[5]}),
          wr ? 32'b011110 : 32'b000000);
      if (wr) begin
         chk({tag, " dq lo"}, {dt[1], dt[2]}, {wdata[15:0], wdata[15:0]});
         chk({tag, " dq hi"}, {dt[3], dt[4]}, {wdata[31:16], wdata[31:16]});
      end
      chk({tag, " read_data"}, rdv, exp_rd);
   endtask

   initial begin
      logic [11:0] rdy_b, we_b;
      logic [6:0]  rdy_c, we_c;
      logic [17:0] addr_c3;
      logic [31:0] rd_c5;

      vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'h00002, 32'h00000000};
      vecs[1] = '{1'b1, 1'b0, 32'd1030, 32'h00000000, 18'h00002, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'd2048, 32'h12345678, 18'h00200, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b0, 32'd2048, 32'h00000000, 18'h00200, 32'h12345678};
      vecs[4] = '{1'b0, 1'b1, 32'd0,    32'hCAFEF00D, 18'h3FE00, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 32'd3,    32'h00000000, 18'h3FE00, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'h00002, 32'hDEADBEEF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset read_data", o_read_data, 32'h0);
      chk("reset sram_addr", 32'(o_sram_addr), 32'h0);
      chk("reset dq_out", 32'(o_sram_dq_out), 32'h0);

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("idle c%0d ready/we_n/oe", k),
             32'({o_ready, o_sram_we_n, o_sram_dq_oe}), 32'b110);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++)
         run_vec($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].lo, vecs[i].exp_rd);

      // Store with the request held through DONE: one IDLE gap, then a second access.
      rdy_b = '0; we_b = '0;
      i_wr_en = 1'b1; i_address = 32'd1028; i_write_data = 32'hA5A55A5A;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         rdy_b[k] = o_ready;
         we_b[k]  = o_sram_we_n;
      end
      @(posedge clk); #1;
      i_wr_en = 1'b0;
      chk("held ready pattern", 32'(rdy_b), 32'b1000_0010_0000);
      chk("held we_n pattern", 32'(we_b), 32'b1000_0110_0001);

      // Load whose inputs change mid-access; the latched request must win.
      rdy_c = '0; we_c = '0; addr_c3 = '0; rd_c5 = '0;
      i_rd_en = 1'b1; i_address = 32'd1028;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         rdy_c[k] = o_ready;
         we_c[k]  = o_sram_we_n;
         if (k == 3) addr_c3 = o_sram_addr;
         if (k == 5) rd_c5 = o_read_data;
         if (k == 2) begin
            i_rd_en = 1'b0; i_wr_en = 1'b1; i_address = 32'd2048; i_write_data = 32'h0BADF00D;
         end
         if (k == 4) begin
            i_rd_en = 1'b0; i_wr_en = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("midchg ready pattern", 32'(rdy_c), 32'b1100000);
      chk("midchg we_n pattern", 32'(we_c), 32'b1111111);
      chk("midchg hi addr", 32'(addr_c3), 32'h3);
      chk("midchg read_data", rd_c5, 32'hA5A55A5A);

      // Reset during the HIGH phase of a store.
      i_wr_en = 1'b1; i_address = 32'd1028; i_write_data = 32'h11112222;
      for (int k = 0; k < 4; k++) @(negedge clk);
      chk("rstmid in HIGH we_n/addr", 32'({o_sram_we_n, o_sram_addr}), 32'({1'b0, 18'h3}));
      #1;
      rst = 1'b1;
      i_wr_en = 1'b0;
      @(negedge clk);
      chk("rstmid ready/we_n/oe", 32'({o_ready, o_sram_we_n, o_sram_dq_oe}), 32'b110);
      chk("rstmid read_data", o_read_data, 32'h0);
      chk("rstmid sram_addr", 32'(o_sram_addr), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rstmid mem lo", 32'(mem[2]), 32'h2222);
      chk("rstmid mem hi", 32'(mem[3]), 32'hA5A5);
      run_vec("post-reset load", 1'b1, 1'b0, 32'd1028, 32'h0, 18'h2, 32'hA5A52222);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
